// File: rtl/text_console_writer_if.sv
// Character-stream and glyph-memory port bundle for text_console_writer.
// slave is the writer itself; master is the character source plus glyph memory.
interface text_console_writer_if;
  logic        char_valid;
  logic [7:0]  char_data;
  logic [7:0]  char_attr;
  logic        char_ready;
  logic        clear;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wd;
  logic [15:0] mem_rd;
  logic        busy;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;

  modport slave (
    input  char_valid, char_data, char_attr, clear, mem_rd,
    output char_ready, mem_we, mem_addr, mem_wd, busy, cursor_col, cursor_row
  );

  modport master (
    output char_valid, char_data, char_attr, clear, mem_rd,
    input  char_ready, mem_we, mem_addr, mem_wd, busy, cursor_col, cursor_row
  );
endinterface

// File: rtl/text_console_writer.sv
// Text-mode character sink: writes printable codes at the cursor, handles LF/CR/BS,
// clears the screen and scrolls one row through the glyph memory's processor port.
module text_console_writer #(
  parameter int          COLS = 80,
  parameter int          ROWS = 60,
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] FILL = 16'h0020
) (
  input logic                  clk,
  input logic                  rst,
  text_console_writer_if.slave bus
);

  localparam logic [12:0] LAST_CELL   = 13'(COLS * ROWS - 1);
  localparam logic [12:0] LAST_SCROLL = 13'((ROWS - 1) * COLS - 1);
  localparam logic [12:0] FILL_START  = 13'((ROWS - 1) * COLS);
  localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW    = 6'(ROWS - 1);
  localparam logic [15:0] ROW_STRIDE  = 16'(COLS);

  typedef enum logic [2:0] {CLR, IDLE, WR, SCR_RD, SCR_WR, SCR_FILL} state_t;
  // WR doubles as the single busy cycle for CR, non-scrolling LF, BS at col 0 and ignored codes.
  typedef enum logic [1:0] {OP_NONE, OP_PRINT, OP_BS} op_t;

  state_t      state, state_d;
  op_t         op, op_d;
  logic [12:0] cnt, cnt_d;
  logic [6:0]  col, col_d;
  logic [5:0]  row, row_d;
  logic        we, we_d;
  logic [15:0] addr, addr_d;
  logic [15:0] wd, wd_d;

  function automatic logic [15:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
    logic [12:0] off;
    off = 13'(r) * 13'(COLS) + 13'(c);
    return BASE + {3'b000, off};
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state;
    op_d    = op;
    cnt_d   = cnt;
    col_d   = col;
    row_d   = row;
    we_d    = 1'b0;
    addr_d  = addr;
    wd_d    = wd;

    case (state)
      CLR: begin
        // After reset the first CLR cycle has no write yet, so the count restarts at 0.
        if (!(we && cnt == LAST_CELL)) begin
          cnt_d  = we ? cnt + 13'd1 : 13'd0;
          we_d   = 1'b1;
          addr_d = BASE + 16'(cnt_d);
          wd_d   = FILL;
        end else begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (bus.clear) begin
          state_d = CLR;
          cnt_d   = 13'd0;
          we_d    = 1'b1;
          addr_d  = BASE;
          wd_d    = FILL;
          col_d   = 7'd0;
          row_d   = 6'd0;
        end else if (bus.char_valid) begin
          state_d = WR;
          op_d    = OP_NONE;
          if (bus.char_data >= 8'h20 && bus.char_data <= 8'h7E) begin
            op_d   = OP_PRINT;
            we_d   = 1'b1;
            addr_d = cell_addr(row, col);
            wd_d   = {bus.char_attr, bus.char_data};
          end else if (bus.char_data == 8'h0A) begin
            col_d = 7'd0;
            if (row == LAST_ROW) begin
              state_d = SCR_RD;
              cnt_d   = 13'd0;
              addr_d  = BASE + ROW_STRIDE;
            end else begin
              row_d = row + 6'd1;
            end
          end else if (bus.char_data == 8'h0D) begin
            col_d = 7'd0;
          end else if (bus.char_data == 8'h08 && col != 7'd0) begin
            op_d   = OP_BS;
            we_d   = 1'b1;
            addr_d = cell_addr(row, col - 7'd1);
            wd_d   = {bus.char_attr, 8'h20};
          end
        end
      end

      WR: begin
        state_d = IDLE;
        if (op == OP_PRINT) begin
          if (col == LAST_COL) begin
            col_d = 7'd0;
            if (row == LAST_ROW) begin
              state_d = SCR_RD;
              cnt_d   = 13'd0;
              addr_d  = BASE + ROW_STRIDE;
            end else begin
              row_d = row + 6'd1;
            end
          end else begin
            col_d = col + 7'd1;
          end
        end else if (op == OP_BS) begin
          col_d = col - 7'd1;
        end
      end

      SCR_RD: begin
        state_d = SCR_WR;
        we_d    = 1'b1;
        addr_d  = BASE + 16'(cnt);
      end

      SCR_WR: begin
        if (cnt == LAST_SCROLL) begin
          state_d = SCR_FILL;
          cnt_d   = FILL_START;
          we_d    = 1'b1;
          addr_d  = BASE + 16'(FILL_START);
          wd_d    = FILL;
        end else begin
          state_d = SCR_RD;
          cnt_d   = cnt + 13'd1;
          addr_d  = BASE + 16'(cnt_d) + ROW_STRIDE;
        end
      end

      SCR_FILL: begin
        if (cnt == LAST_CELL) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt + 13'd1;
          we_d   = 1'b1;
          addr_d = BASE + 16'(cnt_d);
          wd_d   = FILL;
        end
      end

      default: state_d = CLR;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; the comb block above uses blocking ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLR;
      op    <= OP_NONE;
      cnt   <= 13'd0;
      col   <= 7'd0;
      row   <= 6'd0;
      we    <= 1'b0;
      addr  <= 16'h0000;
      wd    <= 16'h0000;
    end else begin
      state <= state_d;
      op    <= op_d;
      cnt   <= cnt_d;
      col   <= col_d;
      row   <= row_d;
      we    <= we_d;
      addr  <= addr_d;
      wd    <= wd_d;
    end
  end

  assign bus.mem_we     = we;
  assign bus.mem_addr   = addr;
  // Scroll copies forward the word read back one cycle after SCR_RD presented its address.
  assign bus.mem_wd     = (state == SCR_WR) ? bus.mem_rd : wd;
  assign bus.char_ready = (state == IDLE) && !bus.clear;
  assign bus.busy       = (state != IDLE);
  assign bus.cursor_col = col;
  assign bus.cursor_row = row;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed plus random character streams checked
// against a screen-array model and a synchronous glyph RAM kept in the bench.
module tb_text_console_writer;
  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_console_writer_if bus();

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .BASE(16'h0000), .FILL(16'h0020)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Glyph RAM: port sampled mid-cycle, written and read on the rising edge.
  logic [15:0] ram [0:CELLS-1];
  logic        we_s = 1'b0;
  logic [15:0] addr_s = 16'h0, wd_s = 16'h0, rd_q = 16'h0;
  logic        preload = 1'b0;
  assign bus.mem_rd = rd_q;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < CELLS; i++) ram[i] <= 16'(i);
    end else if (we_s && addr_s < 16'(CELLS)) begin
      ram[addr_s[12:0]] <= wd_s;
    end
    rd_q <= (addr_s < 16'(CELLS)) ? ram[addr_s[12:0]] : 16'h0;
  end

  int          cyc = 0;
  int          idle_we = 0;
  logic [31:0] wlog[$];
  int          acc_cyc[$];

  always @(negedge clk) begin
    cyc++;
    we_s   <= bus.mem_we;
    addr_s <= bus.mem_addr;
    wd_s   <= bus.mem_wd;
    if (bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_wd});
    if (bus.mem_we && !bus.busy) idle_we++;
    if (bus.char_valid && bus.char_ready) acc_cyc.push_back(cyc);
  end

  // Reference model: the screen as a 2-D array plus a cursor.
  logic [15:0] scr [ROWS][COLS];
  int mr, mc;

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 16'h0020;
    mr = 0;
    mc = 0;
  endtask

  task automatic model_newline();
    if (mr == ROWS - 1) begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 16'h0020;
    end else begin
      mr++;
    end
  endtask

  task automatic model_put(input logic [7:0] d, input logic [7:0] a);
    if (d >= 8'h20 && d <= 8'h7E) begin
      scr[mr][mc] = {a, d};
      mc++;
      if (mc == COLS) begin
        mc = 0;
        model_newline();
      end
    end else if (d == 8'h0A) begin
      mc = 0;
      model_newline();
    end else if (d == 8'h0D) begin
      mc = 0;
    end else if (d == 8'h08 && mc > 0) begin
      mc--;
      scr[mr][mc] = {a, 8'h20};
    end
  endtask

  task automatic check_screen(input string tag);
    int bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (ram[r*COLS + c] !== scr[r][c]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, 32'(bus.cursor_row), mr);
    check({tag, "_col"}, 32'(bus.cursor_col), mc);
  endtask

  task automatic check_clear_log(input string tag);
    int bad = 0;
    check({tag, "_writes"}, wlog.size(), CELLS);
    foreach (wlog[i]) if (wlog[i] !== {16'(i), 16'h0020}) bad++;
    check({tag, "_order"}, bad, 0);
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'(bus.busy), 0);
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (bus.char_valid && bus.char_ready) ok = 1;
    end
    if (!ok) check("accept_timeout", 32'(bus.char_ready), 1);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    @(posedge clk); #1;
    bus.char_data  = d;
    bus.char_attr  = a;
    bus.char_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] d, input logic [7:0] a);
    int n;
    send(d, a);
    wait_idle(20000, n);
    model_put(d, a);
  endtask

  initial begin
    int n, n0, bad;
    logic [7:0] d, a;

    rst = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.char_attr  = 8'h00;
    bus.clear      = 1'b0;

    // Reset values, then the power-up clear.
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wd", 32'(bus.mem_wd), 0);
    check("rst_busy", 32'(bus.busy), 1);
    check("rst_ready", 32'(bus.char_ready), 0);
    check("rst_cursor", {bus.cursor_row, bus.cursor_col}, 0);
    wlog.delete();
    rst = 1'b1;
    wait_idle(6000, n);
    check_clear_log("init_clear");
    check("init_ready", 32'(bus.char_ready), 1);
    model_clear();
    check_cursor("init_cursor");
    check_screen("init_screen");

    // 'A' then 'B' with valid held high: two writes, accepts exactly 2 cycles apart.
    wlog.delete();
    n0 = acc_cyc.size();
    @(posedge clk); #1;
    bus.char_data = 8'h41; bus.char_attr = 8'h1F; bus.char_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    bus.char_data = 8'h42;
    wait_accept();
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
    wait_idle(50, n);
    model_put(8'h41, 8'h1F);
    model_put(8'h42, 8'h1F);
    check("ab_writes", wlog.size(), 2);
    check("ab_w0", (wlog.size() > 0) ? wlog[0] : 32'hFFFF_FFFF, {16'd0, 16'h1F41});
    check("ab_w1", (wlog.size() > 1) ? wlog[1] : 32'hFFFF_FFFF, {16'd1, 16'h1F42});
    check("ab_gap", (acc_cyc.size() >= n0 + 2) ? acc_cyc[n0+1] - acc_cyc[n0] : -1, 2);
    check_cursor("ab_cursor");

    // Walk to (3,79), then wrap with 'Z' and try BS at column 0.
    put(8'h0D, 8'h00);
    repeat (3) put(8'h0A, 8'h00);
    for (int i = 0; i < COLS - 1; i++) put(8'(8'h61 + i % 26), 8'h07);
    check("pre_wrap_row", 32'(bus.cursor_row), 3);
    check("pre_wrap_col", 32'(bus.cursor_col), 79);
    wlog.delete();
    put(8'h5A, 8'h4E);
    check("wrap_writes", wlog.size(), 1);
    check("wrap_w0", (wlog.size() > 0) ? wlog[0] : 32'hFFFF_FFFF, {16'd319, 16'h4E5A});
    check("wrap_row", 32'(bus.cursor_row), 4);
    check("wrap_col", 32'(bus.cursor_col), 0);
    wlog.delete();
    put(8'h08, 8'h33);
    check("bs0_writes", wlog.size(), 0);
    check_cursor("bs0_cursor");

    // Random character stream against the model.
    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(0, 99);
      a = 8'($urandom_range(0, 255));
      if (n < 70)      d = 8'($urandom_range(32, 126));
      else if (n < 80) d = 8'h0A;
      else if (n < 87) d = 8'h0D;
      else if (n < 95) d = 8'h08;
      else begin
        d = 8'($urandom_range(0, 31));
        if (d == 8'h08 || d == 8'h0A || d == 8'h0D) d = 8'h7F;
      end
      put(d, a);
      check_cursor("rand_cursor");
    end
    check_screen("rand_screen");

    // clear together with char_valid: no accept, full fill, cursor home, 4800 busy cycles.
    wlog.delete();
    n0 = acc_cyc.size();
    @(posedge clk); #1;
    bus.clear = 1'b1; bus.char_valid = 1'b1; bus.char_data = 8'h51;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.char_valid = 1'b0;
    wait_idle(6000, n);
    check("clr_busy_cycles", n, CELLS);
    check("clr_no_accept", acc_cyc.size() - n0, 0);
    check_clear_log("clr");
    model_clear();
    check_cursor("clr_cursor");
    check_screen("clr_screen");

    // Scroll: cursor to (59,0), memory holds its own address, then LF.
    repeat (ROWS - 1) put(8'h0A, 8'h00);
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 16'(r*COLS + c);
    send(8'h0A, 8'h00);
    wait_idle(20000, n);
    model_put(8'h0A, 8'h00);
    check("scr_busy_cycles", n, 9520);
    check("scr_addr0", 32'(ram[0]), 80);
    check("scr_addr4719", 32'(ram[4719]), 4799);
    bad = 0;
    for (int i = 4720; i < CELLS; i++) if (ram[i] !== 16'h0020) bad++;
    check("scr_last_row_fill", bad, 0);
    check_cursor("scr_cursor");
    check_screen("scr_screen");

    // Reset mid-scroll during a write cycle: immediate abort, then a full clear.
    send(8'h0A, 8'h00);
    repeat (200) @(negedge clk);
    for (int i = 0; i < 10 && !bus.mem_we; i++) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_we", 32'(bus.mem_we), 0);
    check("abort_busy", 32'(bus.busy), 1);
    check("abort_ready", 32'(bus.char_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    wlog.delete();
    rst = 1'b1;
    wait_idle(6000, n);
    check_clear_log("abort_clear");
    model_clear();
    check_cursor("abort_cursor");
    check_screen("abort_screen");

    check("we_in_idle", idle_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
